// File: rtl/program_counter_unit_pkg.sv
// Shared encodings for the A09 program counter unit: next-PC source select,
// branch addressing mode and the branch offset field position in IR.
package program_counter_unit_pkg;

  // PC_Src encodings
  localparam logic [1:0] PCSRC_BRANCH = 2'b00;
  localparam logic [1:0] PCSRC_RETURN = 2'b01;
  localparam logic [1:0] PCSRC_REG    = 2'b10;
  localparam logic [1:0] PCSRC_RSVD   = 2'b11;

  // BRA_Src encodings
  localparam logic BRASRC_ABS = 1'b0;  // Src1 register, absolute target
  localparam logic BRASRC_REL = 1'b1;  // PC + sext(IR[9:0])

  // Branch offset field IR[BR_OFF_MSB:BR_OFF_LSB]
  localparam int BR_OFF_MSB = 9;
  localparam int BR_OFF_LSB = 0;
  localparam int BR_OFF_W   = BR_OFF_MSB - BR_OFF_LSB + 1;

endpackage

// File: rtl/program_counter_unit_if.sv
// Sequencer <-> program counter unit bundle. All strobes are active-low.
// There is no valid/ready handshake: every strobe is sampled on each rising
// Clk edge, and all outputs reflect registered state (new PC one cycle later).
interface program_counter_unit_if #(
  parameter int DataWidth  = 16,
  parameter int StackDepth = 8
);
  localparam int DepthW = $clog2(StackDepth) + 1;

  logic                 PC_Rst;
  logic                 PC_Ld;
  logic                 PC_Inc;
  logic [1:0]           PC_Src;
  logic                 BRA_Src;
  logic                 STK_Ld;
  logic [DataWidth-1:0] IR;
  logic [DataWidth-1:0] Src1;
  logic [DataWidth-1:0] PC_Out;
  logic [DataWidth-1:0] STK_Top;
  logic [DepthW-1:0]    STK_Depth;
  logic                 STK_Ovf;
  logic                 STK_Unf;

  // Sequencer side
  modport master (
    output PC_Rst, PC_Ld, PC_Inc, PC_Src, BRA_Src, STK_Ld, IR, Src1,
    input  PC_Out, STK_Top, STK_Depth, STK_Ovf, STK_Unf
  );

  // Program counter unit side
  modport slave (
    input  PC_Rst, PC_Ld, PC_Inc, PC_Src, BRA_Src, STK_Ld, IR, Src1,
    output PC_Out, STK_Top, STK_Depth, STK_Ovf, STK_Unf
  );
endinterface

// File: rtl/program_counter_unit_return_stack.sv
// Saturating return-address stack: register array plus entry count.
// Pop has priority over push; full/empty never wrap, they set sticky flags.
module program_counter_unit_return_stack #(
  parameter int                   DataWidth   = 16,
  parameter int                   StackDepth  = 8,
  parameter logic [DataWidth-1:0] ResetVector = '0
) (
  input  logic                            clk_i,
  input  logic                            clr_i,
  input  logic                            push_i,
  input  logic                            pop_i,
  input  logic [DataWidth-1:0]            push_data_i,
  output logic [DataWidth-1:0]            top_o,
  output logic [$clog2(StackDepth):0]     depth_o,
  output logic                            empty_o,
  output logic                            ovf_o,
  output logic                            unf_o
);
  localparam int AW  = $clog2(StackDepth);
  localparam int DPW = AW + 1;
  localparam logic [DPW-1:0] FULL = DPW'(StackDepth);

  logic [DataWidth-1:0] mem_q [StackDepth];
  logic [DPW-1:0]       depth_q, depth_d;
  logic                 ovf_q, ovf_d;
  logic                 unf_q, unf_d;
  logic                 wr_en;
  logic [AW-1:0]        wr_idx, top_idx;

  assign wr_idx  = depth_q[AW-1:0];
  assign top_idx = depth_q[AW-1:0] - AW'(1);
  assign empty_o = (depth_q == '0);
  assign top_o   = empty_o ? ResetVector : mem_q[top_idx];
  assign depth_o = depth_q;
  assign ovf_o   = ovf_q;
  assign unf_o   = unf_q;

  // Next depth/flags; clear dominates, then pop, then push
  always_comb begin
    depth_d = depth_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    wr_en   = 1'b0;
    if (clr_i) begin
      depth_d = '0;
      ovf_d   = 1'b0;
      unf_d   = 1'b0;
    end else if (pop_i) begin
      if (empty_o) unf_d   = 1'b1;
      else         depth_d = depth_q - DPW'(1);
    end else if (push_i) begin
      if (depth_q == FULL) begin
        ovf_d = 1'b1;
      end else begin
        wr_en   = 1'b1;
        depth_d = depth_q + DPW'(1);
      end
    end
  end

  // Pointer and sticky flags
  always_ff @(posedge clk_i) begin
    depth_q <= depth_d;
    ovf_q   <= ovf_d;
    unf_q   <= unf_d;
  end

  // Entry storage; contents are don't-care above the current depth
  always_ff @(posedge clk_i) begin
    if (wr_en) mem_q[wr_idx] <= push_data_i;
  end
endmodule

// File: rtl/program_counter_unit.sv
// A09 program counter unit: PC register and next-PC mux, with the return
// stack for JPL/RET. Priority per edge: Reset > PC_Rst > PC_Ld > PC_Inc > hold.
module program_counter_unit
  import program_counter_unit_pkg::*;
#(
  parameter int                   DataWidth   = 16,
  parameter int                   StackDepth  = 8,
  parameter logic [DataWidth-1:0] ResetVector = '0
) (
  input  logic                   Clk,
  input  logic                   Reset,
  program_counter_unit_if.slave  bus
);
  logic [DataWidth-1:0] pc_q, pc_d;
  logic [DataWidth-1:0] br_off;
  logic [DataWidth-1:0] stk_top;
  logic                 stk_empty;
  logic                 clr;
  logic                 ld;
  logic                 push;
  logic                 pop;

  assign clr = Reset | ~bus.PC_Rst;
  assign ld  = ~bus.PC_Ld;
  assign br_off = {{(DataWidth-BR_OFF_W){bus.IR[BR_OFF_MSB]}},
                   bus.IR[BR_OFF_MSB:BR_OFF_LSB]};

  // Stack only acts on loads; a return pop overrides a simultaneous push,
  // and the reserved source performs no stack action.
  assign pop  = ld && (bus.PC_Src == PCSRC_RETURN);
  assign push = ld && !bus.STK_Ld &&
                ((bus.PC_Src == PCSRC_BRANCH) || (bus.PC_Src == PCSRC_REG));

  program_counter_unit_return_stack #(
    .DataWidth   (DataWidth),
    .StackDepth  (StackDepth),
    .ResetVector (ResetVector)
  ) u_stack (
    .clk_i       (Clk),
    .clr_i       (clr),
    .push_i      (push),
    .pop_i       (pop),
    .push_data_i (pc_q),
    .top_o       (stk_top),
    .depth_o     (bus.STK_Depth),
    .empty_o     (stk_empty),
    .ovf_o       (bus.STK_Ovf),
    .unf_o       (bus.STK_Unf)
  );

  // Next-PC selection
  always_comb begin
    pc_d = pc_q;
    if (clr) begin
      pc_d = ResetVector;
    end else if (ld) begin
      case (bus.PC_Src)
        PCSRC_BRANCH: pc_d = (bus.BRA_Src == BRASRC_REL) ? pc_q + br_off : bus.Src1;
        PCSRC_RETURN: pc_d = stk_empty ? ResetVector : stk_top;
        PCSRC_REG:    pc_d = bus.Src1;
        default:      pc_d = pc_q;
      endcase
    end else if (!bus.PC_Inc) begin
      pc_d = pc_q + DataWidth'(1);
    end
  end

  // PC register
  always_ff @(posedge Clk) begin
    pc_q <= pc_d;
  end

  assign bus.PC_Out  = pc_q;
  assign bus.STK_Top = stk_top;
endmodule
